// File: rtl/col_parity_engine.sv
// Column-parity engine: streams NBLK DIMxDIM lane states from a sync-read RAM, folds each column
// into an accumulator and writes DIM result lanes per state (plain parity or theta D[x]).
module col_parity_engine #(
   parameter int unsigned LANE_W = 64,
   parameter int unsigned DIM    = 5,
   parameter int unsigned NBLK   = 4,
   parameter int unsigned RD_AW  = 7,
   parameter int unsigned WR_AW  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   input  logic              abort,
   output logic              rd_en,
   output logic [RD_AW-1:0]  rd_addr,
   input  logic [LANE_W-1:0] rd_data,
   output logic              wr_en,
   output logic [WR_AW-1:0]  wr_addr,
   output logic [LANE_W-1:0] wr_data,
   output logic              busy,
   output logic              done
);

   localparam int unsigned XW = (DIM > 1) ? $clog2(DIM) : 1;
   localparam int unsigned BW = (NBLK > 1) ? $clog2(NBLK) : 1;
   localparam logic [XW-1:0] XLast = XW'(DIM - 1);
   localparam logic [BW-1:0] BLast = BW'(NBLK - 1);

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StDrain,
      StWrite,
      StDone
   } state_e;

   state_e            state_q;
   logic              mode_q;
   logic [XW-1:0]     x_q;
   logic [XW-1:0]     y_q;
   logic [XW-1:0]     wj_q;
   logic [BW-1:0]     blk_q;
   logic [RD_AW-1:0]  rd_ptr_q;
   logic [WR_AW-1:0]  wr_ptr_q;
   logic              rd_vld_q;
   logic [XW-1:0]     rd_x_q;
   logic [LANE_W-1:0] acc_q [DIM];

   logic [XW-1:0]     j_prev;
   logic [XW-1:0]     j_next;
   logic [LANE_W-1:0] a_prev;
   logic [LANE_W-1:0] a_next;
   logic [LANE_W-1:0] theta;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         mode_q   <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         wj_q     <= '0;
         blk_q    <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         rd_vld_q <= 1'b0;
         rd_x_q   <= '0;
         for (int i = 0; i < int'(DIM); i++) acc_q[i] <= '0;
      end else begin
         // Read data arrives one cycle after its strobe; an aborted read is dropped.
         rd_vld_q <= (state_q == StRead) && !abort;
         rd_x_q   <= x_q;
         if (rd_vld_q) acc_q[rd_x_q] <= acc_q[rd_x_q] ^ rd_data;

         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q  <= StRead;
                  mode_q   <= mode;
                  x_q      <= '0;
                  y_q      <= '0;
                  wj_q     <= '0;
                  blk_q    <= '0;
                  rd_ptr_q <= '0;
                  wr_ptr_q <= '0;
                  for (int i = 0; i < int'(DIM); i++) acc_q[i] <= '0;
               end
            end
            StRead: begin
               if (abort) begin
                  state_q <= StIdle;
               end else begin
                  rd_ptr_q <= rd_ptr_q + RD_AW'(1);
                  if (x_q == XLast) begin
                     x_q <= '0;
                     if (y_q == XLast) begin
                        y_q     <= '0;
                        state_q <= StDrain;
                     end else begin
                        y_q <= y_q + XW'(1);
                     end
                  end else begin
                     x_q <= x_q + XW'(1);
                  end
               end
            end
            StDrain: begin
               if (abort) begin
                  state_q <= StIdle;
               end else begin
                  wj_q    <= '0;
                  state_q <= StWrite;
               end
            end
            StWrite: begin
               if (abort) begin
                  state_q <= StIdle;
               end else begin
                  wr_ptr_q <= wr_ptr_q + WR_AW'(1);
                  if (wj_q == XLast) begin
                     wj_q <= '0;
                     if (blk_q == BLast) begin
                        state_q <= StDone;
                     end else begin
                        blk_q   <= blk_q + BW'(1);
                        state_q <= StRead;
                        for (int i = 0; i < int'(DIM); i++) acc_q[i] <= '0;
                     end
                  end else begin
                     wj_q <= wj_q + XW'(1);
                  end
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Theta: left neighbour column xor right neighbour column rotated left by one.
   always_comb begin
      j_prev = (wj_q == '0) ? XLast : wj_q - XW'(1);
      j_next = (wj_q == XLast) ? '0 : wj_q + XW'(1);
      a_prev = acc_q[j_prev];
      a_next = acc_q[j_next];
      theta  = a_prev ^ {a_next[LANE_W-2:0], a_next[LANE_W-1]};
   end

   always_comb begin
      rd_en   = 1'b0;
      rd_addr = '0;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      busy    = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         StRead: begin
            rd_en   = 1'b1;
            rd_addr = rd_ptr_q;
            busy    = 1'b1;
         end
         StDrain: begin
            busy = 1'b1;
         end
         StWrite: begin
            wr_en   = 1'b1;
            wr_addr = wr_ptr_q;
            wr_data = mode_q ? theta : acc_q[wj_q];
            busy    = 1'b1;
         end
         StDone: begin
            done = 1'b1;
         end
         default: begin
            done = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_col_parity_engine.sv
// Self-checking bench for col_parity_engine: three instances (single block, four blocks, narrow
// 3x3 with 8-bit lanes) checked against a column-xor reference model.
module tb_col_parity_engine;

   typedef struct {
      int          addr;
      logic [63:0] data;
      int          cyc;
   } wr_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   int   cyc = 0;
   int   start_cyc = 0;
   int   errors = 0;
   int   checks = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Instance A: 64-bit, 5x5, one block
   logic        start_a, mode_a, abort_a, rd_en_a, wr_en_a, busy_a, done_a;
   logic [6:0]  rd_addr_a;
   logic [4:0]  wr_addr_a;
   logic [63:0] rd_data_a, wr_data_a;
   // Instance B: defaults, four blocks
   logic        start_b, mode_b, abort_b, rd_en_b, wr_en_b, busy_b, done_b;
   logic [6:0]  rd_addr_b;
   logic [4:0]  wr_addr_b;
   logic [63:0] rd_data_b, wr_data_b;
   // Instance C: 8-bit, 3x3, one block
   logic        start_c, mode_c, abort_c, rd_en_c, wr_en_c, busy_c, done_c;
   logic [3:0]  rd_addr_c;
   logic [1:0]  wr_addr_c;
   logic [7:0]  rd_data_c, wr_data_c;

   col_parity_engine #(.LANE_W(64), .DIM(5), .NBLK(1), .RD_AW(7), .WR_AW(5)) u_a (
      .clk(clk), .rst(rst), .start(start_a), .mode(mode_a), .abort(abort_a),
      .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
      .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
      .busy(busy_a), .done(done_a)
   );
   col_parity_engine #(.LANE_W(64), .DIM(5), .NBLK(4), .RD_AW(7), .WR_AW(5)) u_b (
      .clk(clk), .rst(rst), .start(start_b), .mode(mode_b), .abort(abort_b),
      .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
      .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
      .busy(busy_b), .done(done_b)
   );
   col_parity_engine #(.LANE_W(8), .DIM(3), .NBLK(1), .RD_AW(4), .WR_AW(2)) u_c (
      .clk(clk), .rst(rst), .start(start_c), .mode(mode_c), .abort(abort_c),
      .rd_en(rd_en_c), .rd_addr(rd_addr_c), .rd_data(rd_data_c),
      .wr_en(wr_en_c), .wr_addr(wr_addr_c), .wr_data(wr_data_c),
      .busy(busy_c), .done(done_c)
   );

   logic [63:0] mem_a [25];
   logic [63:0] mem_b [100];
   logic [7:0]  mem_c [9];
   logic [63:0] model_mem [100];

   always @(posedge clk) begin
      if (rd_en_a) rd_data_a <= mem_a[rd_addr_a];
      if (rd_en_b) rd_data_b <= mem_b[rd_addr_b];
      if (rd_en_c) rd_data_c <= mem_c[rd_addr_c];
   end

   wr_t wq_a[$], wq_b[$], wq_c[$];
   int  dq_a[$], dq_b[$], dq_c[$];
   wr_t tmp_a, tmp_b, tmp_c;
   int  busy_cnt_a = 0, busy_first_a = 0, busy_last_a = 0;
   int  rdcnt_b [100];
   int  rd_total_b = 0;

   always @(negedge clk) begin
      if (wr_en_a) begin
         tmp_a.addr = int'(wr_addr_a); tmp_a.data = wr_data_a; tmp_a.cyc = cyc - start_cyc;
         wq_a.push_back(tmp_a);
      end
      if (done_a) dq_a.push_back(cyc - start_cyc);
      if (busy_a) begin
         if (busy_cnt_a == 0) busy_first_a = cyc - start_cyc;
         busy_last_a = cyc - start_cyc;
         busy_cnt_a++;
      end
      if (wr_en_b) begin
         tmp_b.addr = int'(wr_addr_b); tmp_b.data = wr_data_b; tmp_b.cyc = cyc - start_cyc;
         wq_b.push_back(tmp_b);
      end
      if (done_b) dq_b.push_back(cyc - start_cyc);
      if (rd_en_b) begin
         rd_total_b++;
         if (int'(rd_addr_b) < 100) rdcnt_b[rd_addr_b]++;
      end
      if (wr_en_c) begin
         tmp_c.addr = int'(wr_addr_c); tmp_c.data = 64'(wr_data_c); tmp_c.cyc = cyc - start_cyc;
         wq_c.push_back(tmp_c);
      end
      if (done_c) dq_c.push_back(cyc - start_cyc);
   end

   function automatic logic [63:0] rotl1(input logic [63:0] v, input int w);
      logic [63:0] mask;
      mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      return ((v << 1) | (v >> (w - 1))) & mask;
   endfunction

   function automatic logic [63:0] ref_col(input int base, input int dim, input int x);
      logic [63:0] c = '0;
      for (int y = 0; y < dim; y++) c ^= model_mem[base + x + dim * y];
      return c;
   endfunction

   function automatic logic [63:0] ref_out(input int base, input int dim, input int w,
                                           input int m, input int x);
      if (m == 0) return ref_col(base, dim, x);
      return ref_col(base, dim, (x + dim - 1) % dim) ^ rotl1(ref_col(base, dim, (x + 1) % dim), w);
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // kind 0 random, 1 one-hot lane index, 2 all ones, 3 single 0x80 in lane 2
   task automatic load(input int inst, input int kind, input int n, input int w);
      logic [63:0] v, mask;
      mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      for (int i = 0; i < n; i++) begin
         case (kind)
            0:       v = {$urandom, $urandom};
            1:       v = 64'd1 << i;
            2:       v = '1;
            default: v = (i == 2) ? 64'h80 : 64'h0;
         endcase
         v = v & mask;
         model_mem[i] = v;
         case (inst)
            0:       mem_a[i] = v;
            1:       mem_b[i] = v;
            default: mem_c[i] = v[7:0];
         endcase
      end
   endtask

   task automatic set_in(input int inst, input logic s, input logic m, input logic a);
      case (inst)
         0:       begin start_a = s; mode_a = m; abort_a = a; end
         1:       begin start_b = s; mode_b = m; abort_b = a; end
         default: begin start_c = s; mode_c = m; abort_c = a; end
      endcase
   endtask

   // Start is sampled at the edge closing cycle 0; returns at the negedge of cycle 1.
   task automatic pulse_start(input int inst, input logic m, input logic with_abort);
      @(negedge clk);
      set_in(inst, 1'b1, m, with_abort);
      start_cyc = cyc;
      @(negedge clk);
      set_in(inst, 1'b0, ~m, 1'b0);
   endtask

   task automatic wait_to(input int c);
      while (cyc - start_cyc < c) @(negedge clk);
   endtask

   task automatic check_job(input int inst, input string tag, input int m, input int nblk,
                            input int dim, input int w);
      wr_t q[$];
      int  d[$];
      int  nw, b, x;
      case (inst)
         0:       begin q = wq_a; d = dq_a; wq_a.delete(); dq_a.delete(); end
         1:       begin q = wq_b; d = dq_b; wq_b.delete(); dq_b.delete(); end
         default: begin q = wq_c; d = dq_c; wq_c.delete(); dq_c.delete(); end
      endcase
      nw = nblk * dim;
      chk({tag, "_nwr"}, 64'(q.size()), 64'(nw));
      for (int i = 0; i < nw && i < q.size(); i++) begin
         b = i / dim;
         x = i % dim;
         chk($sformatf("%s_addr%0d", tag, i), 64'(q[i].addr), 64'(i));
         chk($sformatf("%s_data%0d", tag, i), q[i].data, ref_out(b * dim * dim, dim, w, m, x));
         chk($sformatf("%s_cyc%0d", tag, i), 64'(q[i].cyc),
             64'(1 + b * (dim * dim + 1 + dim) + dim * dim + 1 + x));
      end
      chk({tag, "_ndone"}, 64'(d.size()), 64'd1);
      if (d.size() > 0) chk({tag, "_done_cyc"}, 64'(d[0]), 64'(nblk * (dim * dim + dim + 1) + 1));
   endtask

   initial begin
      int once;
      rst = 1'b1;
      set_in(0, 1'b0, 1'b0, 1'b0);
      set_in(1, 1'b0, 1'b0, 1'b0);
      set_in(2, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      chk("rst_ctrl_a", 64'({rd_en_a, wr_en_a, busy_a, done_a}), 64'd0);
      chk("rst_addr_a", 64'({rd_addr_a, wr_addr_a}), 64'd0);
      chk("rst_data_a", wr_data_a, 64'd0);
      chk("rst_ctrl_c", 64'({rd_en_c, wr_en_c, busy_c, done_c, wr_data_c}), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // One-hot lanes, plain parity
      load(0, 1, 25, 64);
      busy_cnt_a = 0;
      pulse_start(0, 1'b0, 1'b0);
      wait_to(40);
      chk("t1_c1_const", wq_a[1].data, 64'h108421 << 1);
      chk("t1_busy_first", 64'(busy_first_a), 64'd1);
      chk("t1_busy_last", 64'(busy_last_a), 64'd31);
      chk("t1_busy_cnt", 64'(busy_cnt_a), 64'd31);
      check_job(0, "t1", 0, 1, 5, 64);

      // Same lanes, theta
      pulse_start(0, 1'b1, 1'b0);
      wait_to(40);
      chk("t2_d0_const", wq_a[0].data, 64'h14A5294);
      check_job(0, "t2", 1, 1, 5, 64);

      // Abort on the 10th read cycle, then restart with one-hot data
      load(0, 0, 25, 64);
      pulse_start(0, 1'b0, 1'b0);
      wait_to(10);
      abort_a = 1'b1;
      @(negedge clk);
      abort_a = 1'b0;
      chk("t4_rd_en_after_abort", 64'(rd_en_a), 64'd0);
      chk("t4_busy_after_abort", 64'(busy_a), 64'd0);
      repeat (30) @(negedge clk);
      chk("t4_no_done", 64'(dq_a.size()), 64'd0);
      chk("t4_no_write", 64'(wq_a.size()), 64'd0);
      load(0, 1, 25, 64);
      pulse_start(0, 1'b0, 1'b0);
      wait_to(40);
      check_job(0, "t4", 0, 1, 5, 64);

      // Four blocks of all-ones: every address read once
      load(1, 2, 100, 64);
      for (int i = 0; i < 100; i++) rdcnt_b[i] = 0;
      rd_total_b = 0;
      pulse_start(1, 1'b0, 1'b0);
      wait_to(135);
      check_job(1, "t3", 0, 4, 5, 64);
      once = 0;
      for (int i = 0; i < 100; i++) if (rdcnt_b[i] == 1) once++;
      chk("t3_rd_total", 64'(rd_total_b), 64'd100);
      chk("t3_rd_once", 64'(once), 64'd100);

      // Reset during WRITE, then a random theta job with a stray start while busy
      load(1, 0, 100, 64);
      pulse_start(1, 1'b1, 1'b0);
      wait_to(28);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t5_rst_ctrl", 64'({rd_en_b, wr_en_b, busy_b, done_b}), 64'd0);
      chk("t5_rst_addr", 64'({rd_addr_b, wr_addr_b}), 64'd0);
      chk("t5_rst_data", wr_data_b, 64'd0);
      @(negedge clk);
      chk("t5_idle_busy", 64'(busy_b), 64'd0);
      wq_b.delete();
      dq_b.delete();
      pulse_start(1, 1'b1, 1'b0);
      wait_to(50);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      wait_to(145);
      check_job(1, "t5", 1, 4, 5, 64);

      // Narrow instance: rotation wrap; start and abort together
      load(2, 3, 9, 8);
      pulse_start(2, 1'b1, 1'b1);
      chk("t6_start_wins", 64'(busy_c), 64'd1);
      wait_to(20);
      chk("t6_d0", wq_c[0].data, 64'h80);
      chk("t6_d1", wq_c[1].data, 64'h01);
      chk("t6_d2", wq_c[2].data, 64'h00);
      check_job(2, "t6", 1, 1, 3, 8);

      for (int r = 0; r < 4; r++) begin
         load(2, 0, 9, 8);
         pulse_start(2, 1'(r % 2), 1'b0);
         wait_to(20);
         check_job(2, $sformatf("t7_%0d", r), r % 2, 1, 3, 8);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
